flop_bank: RTL
==============

# flop_bank

Parametrised multi-mode register bank that generalises the single-bit SR, JK, D and T flops into one WIDTH-bit register. A runtime mode field selects the per-bit behaviour (D load, T toggle, JK, SR) or whole-word shift/rotate. The bank adds a synchronous clear, a clock enable, a sticky SR-conflict flag and a change-detect pulse. It is the standard state-holding primitive for control/status registers and small shift chains in the datapath.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by async reset and by clr.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low; asserts asynchronously, releases synchronously externally.
- en  input  1  clock enable; when 0, q holds (clr still acts).
- clr  input  1  synchronous clear; loads RESET_VAL, overrides en and mode.
- mode  input  3  operation select (see Operation).
- a  input  WIDTH  D / T / J / S operand, per bit.
- b  input  WIDTH  K / R operand, per bit; ignored outside JK/SR.
- ser_in  input  1  serial input for shift modes.
- err_clr  input  1  synchronous clear of err.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  ~q, combinational from q.
- err  output  1  sticky: an SR-mode write saw s=r=1 on any bit while enabled.
- chg  output  1  one-cycle pulse: q changed value at the last edge.

## Operation
- Priority per edge: rst_n low > clr > en=0 (hold) > mode.
- mode 000 hold: q unchanged.
- mode 001 D: q <= a.
- mode 010 T: q <= q ^ a.
- mode 011 JK per bit: 00 hold, 01 ->0, 10 ->1, 11 toggle.
- mode 100 SR per bit (s=a, r=b): 00 hold, 01 ->0, 10 ->1, 11 hold that bit and set err. Never produce X.
- mode 101 shift left: q <= {q[WIDTH-2:0], ser_in}.
- mode 110 shift right: q <= {ser_in, q[WIDTH-1:1]}.
- mode 111 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; ser_in ignored.
- err: set when en=1, clr=0, mode=100 and |(a&b). Cleared by err_clr or clr. If set and clear conditions coincide, set wins.
- chg <= (q_next != q), evaluated every edge including clr. 0 when the edge leaves q unchanged.

## Timing
- Async reset: q=RESET_VAL, q_bar=~RESET_VAL, err=0, chg=0 immediately on rst_n falling. No clk edge is needed.
- All updates take effect at the first rising clk edge after the inputs settle. Latency is 1 cycle from input to q.
- chg and err update on the same edge as q; chg is high for exactly one cycle per changing edge.
- q_bar follows q with zero cycles of delay.
- Reset mid-shift or mid-toggle sequence aborts it; no residual state survives reset.
- clr with en=0 still clears q and err, and chg pulses if q != RESET_VAL.
- Unused a/b bits in shift, rotate, hold and D modes have no effect on err.

## Test plan
- WIDTH=8, RESET_VAL=8'hA5: pulse rst_n low between edges -> q=A5 and q_bar=5A immediately; err=0, chg=0.
- mode=001, a=3C, en=1 -> q=3C next edge, chg=1 for one cycle. Repeat a=3C -> chg=0.
- mode=011, q=F0, a=FF, b=0F (JK): bits 7:4 have j=1,k=0 -> set; bits 3:0 have j=1,k=1 -> toggle 0->1. Result q=FF, err=0. Then mode=010, a=FF -> q=00.
- mode=100, q=00, a=81, b=01: bit0 has s=r=1 -> holds 0; bit7 set. Result q=80, err=1, and err stays 1 after the mode changes. Assert err_clr with another conflict the same cycle -> err=1. Assert err_clr alone -> err=0.
- mode=101, q=80, ser_in=1 for 3 edges -> q=01, 03, 07. mode=111 on q=81 -> q=03. en=0 -> q holds, chg=0.
- During a shift sequence, assert clr with en=0 -> q=A5, err=0, chg=1. Drop rst_n mid-sequence -> q=A5 asynchronously.

Source files
------------

// File: rtl/flop_bank.sv
// flop_bank: WIDTH-bit register with runtime-selectable per-bit behaviour
// (D, T, JK, SR) or whole-word shift/rotate. It also provides a synchronous
// clear, a clock enable, a sticky SR-conflict flag and a change-detect pulse.
module flop_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ser_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             err,
    output logic             chg
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_D    = 3'b001,
        MODE_T    = 3'b010,
        MODE_JK   = 3'b011,
        MODE_SR   = 3'b100,
        MODE_SHL  = 3'b101,
        MODE_SHR  = 3'b110,
        MODE_ROL  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] sr_set;
    logic [WIDTH-1:0] sr_rst;
    logic             err_set;
    logic             err_next;

    // SR decode: a conflicting bit (s=r=1) asserts neither set nor reset, so it holds.
    assign sr_set  = a & ~b;
    assign sr_rst  = b & ~a;
    assign err_set = en & ~clr & (mode == MODE_SR) & (|(a & b));

    // Next-state selection: clr beats the enable, and the enable beats the mode.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = RESET_VAL;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_HOLD: q_next = q;
                MODE_D:    q_next = a;
                MODE_T:    q_next = q ^ a;
                // j=a, k=b: set where j&~q, keep where ~k&q (covers hold/set/reset/toggle)
                MODE_JK:   q_next = (a & ~q) | (~b & q);
                MODE_SR:   q_next = (q | sr_set) & ~sr_rst;
                MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
                MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
                MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                default:   q_next = q;
            endcase
        end
    end

    // Sticky error: when a new conflict and a clear arrive together, the conflict is kept.
    always_comb begin
        err_next = err;
        if (err_set) begin
            err_next = 1'b1;
        end else if (clr || err_clr) begin
            err_next = 1'b0;
        end
    end

    // State register: reset is asynchronous; chg marks any edge that alters q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= RESET_VAL;
            err <= 1'b0;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            err <= err_next;
            chg <= (q_next != q);
        end
    end

    assign q_bar = ~q;

endmodule
